// File: rtl/pdp8_stim_sequencer.sv
// Stimulus sequencer for the EXEC unit: optional CLA/NOP preamble, then LFSR-driven
// mem/op7 opcode phases paced by EXEC stall, with busy/done/count status.
module pdp8_stim_sequencer #(
   parameter int unsigned           ADDR_WIDTH  = 12,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR  = ADDR_WIDTH'(12'o200),
   parameter logic [17:0]           SEED        = 18'h2A5F3,
   parameter int unsigned           NUM_MEM     = 1000,
   parameter int unsigned           NUM_OP7     = 100,
   parameter int unsigned           HOLD_CYC    = 4,
   parameter bit                    PREAMBLE_EN = 1'b1,
   parameter bit                    ONEHOT_EN   = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] PC_value,
   output logic                  ifu_rd_req,
   output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [ADDR_WIDTH-1:0] base_addr,
   output logic [17:0]           pdp_mem_opcode,
   output logic [21:0]           pdp_op7_opcode,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           instr_count
);

   localparam int unsigned MEM_W  = 18;
   localparam int unsigned OP7_W  = 22;
   localparam int unsigned LFSR_W = 18;
   localparam int unsigned TOTAL  = NUM_MEM + NUM_OP7;
   localparam int unsigned CNT_W  = $clog2(TOTAL);
   localparam int unsigned HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

   localparam logic [HOLD_W-1:0] HOLD_FULL   = HOLD_W'(HOLD_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_SETTLE = HOLD_W'((HOLD_CYC > 1) ? HOLD_CYC - 2 : 0);
   localparam logic [LFSR_W-1:0] SEED_EFF    = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [OP7_W-1:0]  OP7_CLA     = OP7_W'(22'h000800);
   localparam logic [OP7_W-1:0]  OP7_NOP     = OP7_W'(22'h000001);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE_WAIT, S_CLA, S_CLA_HOLD, S_NOP_WAIT, S_NOP, S_NOP_HOLD,
      S_SETTLE, S_MEM_RUN, S_OP7_RUN, S_MIX_RUN, S_DONE
   } state_e;

   state_e              state_q, state_d, run_st;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_adv;
   logic [MEM_W-1:0]    mem_q, mem_d, mem_word;
   logic [OP7_W-1:0]    op7_q, op7_d, op7_word;
   logic [31:0]         count_q, count_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    issue_q, issue_d, issue_last;
   logic [1:0]          mode_q, mode_d;
   logic                settle_armed_q, settle_armed_d;
   logic                load_nop, load_zero, issue_mem;
   logic [5:0]          oh_flags;
   logic                unused_pc;

   assign unused_pc = ^PC_value;

   // Candidate opcodes come from the advanced LFSR value so the first issue sees SEED stepped once
   assign lfsr_adv = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};

   always_comb begin
      oh_flags = '0;
      case (lfsr_adv[17:15])
         3'd0, 3'd6: oh_flags = 6'b000001;
         3'd1, 3'd7: oh_flags = 6'b000010;
         3'd2:       oh_flags = 6'b000100;
         3'd3:       oh_flags = 6'b001000;
         3'd4:       oh_flags = 6'b010000;
         3'd5:       oh_flags = 6'b100000;
      endcase
   end

   assign mem_word = ONEHOT_EN ? {oh_flags, lfsr_adv[11:0]} : lfsr_adv;
   assign op7_word = {lfsr_adv[3:0], lfsr_adv};

   always_comb begin
      case (mode_q)
         2'b10:   run_st = S_OP7_RUN;
         2'b11:   run_st = S_MIX_RUN;
         default: run_st = S_MEM_RUN;
      endcase
   end

   always_comb begin
      case (state_q)
         S_MEM_RUN: issue_last = CNT_W'(NUM_MEM - 1);
         S_OP7_RUN: issue_last = CNT_W'(NUM_OP7 - 1);
         default:   issue_last = CNT_W'(TOTAL - 1);
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      lfsr_d         = lfsr_q;
      mem_d          = mem_q;
      op7_d          = op7_q;
      count_d        = count_q;
      busy_d         = busy_q;
      done_d         = done_q;
      hold_d         = hold_q;
      issue_d        = issue_q;
      mode_d         = mode_q;
      settle_armed_d = settle_armed_q;
      load_nop       = 1'b0;
      load_zero      = 1'b0;
      issue_mem      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            mem_d = '0;
            op7_d = '0;
            if (state_q == S_DONE) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
            if (start) begin
               busy_d         = 1'b1;
               done_d         = 1'b0;
               count_d        = '0;
               issue_d        = '0;
               mode_d         = mode;
               settle_armed_d = 1'b0;
               state_d        = PREAMBLE_EN ? S_PRE_WAIT : S_SETTLE;
            end
         end
         S_PRE_WAIT: begin
            if (!stall) begin
               mem_d   = '0;
               op7_d   = OP7_CLA;
               hold_d  = HOLD_FULL;
               state_d = S_CLA;
            end
         end
         S_CLA, S_CLA_HOLD: begin
            if (hold_q != '0) begin
               hold_d  = hold_q - HOLD_W'(1);
               state_d = S_CLA_HOLD;
            end else if (stall) begin
               state_d = S_NOP_WAIT;
            end else begin
               load_nop = 1'b1;
            end
         end
         S_NOP_WAIT: load_nop = !stall;
         S_NOP, S_NOP_HOLD: begin
            if (hold_q != '0) begin
               hold_d  = hold_q - HOLD_W'(1);
               state_d = S_NOP_HOLD;
            end else if (stall) begin
               settle_armed_d = 1'b0;
               state_d        = S_SETTLE;
            end else begin
               load_zero = 1'b1;
            end
         end
         S_SETTLE: begin
            if (!settle_armed_q) begin
               load_zero = !stall;
            end else if (hold_q == '0) begin
               state_d = run_st;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         S_MEM_RUN, S_OP7_RUN, S_MIX_RUN: begin
            if (!stall) begin
               issue_mem = (state_q == S_MEM_RUN) || ((state_q == S_MIX_RUN) && !lfsr_adv[0]);
               lfsr_d    = lfsr_adv;
               count_d   = (&count_q) ? count_q : count_q + 32'd1;
               mem_d     = issue_mem ? mem_word : '0;
               op7_d     = issue_mem ? '0 : op7_word;
               if (issue_q == issue_last) begin
                  issue_d = '0;
                  state_d = ((state_q == S_MEM_RUN) && (mode_q == 2'b00)) ? S_OP7_RUN : S_DONE;
               end else begin
                  issue_d = issue_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_nop) begin
         mem_d   = '0;
         op7_d   = OP7_NOP;
         hold_d  = HOLD_FULL;
         state_d = S_NOP;
      end
      // Zero window counts its last cycle inside the RUN state, before the first issue edge
      if (load_zero) begin
         mem_d          = '0;
         op7_d          = '0;
         settle_armed_d = 1'b1;
         hold_d         = HOLD_SETTLE;
         state_d        = (HOLD_CYC > 1) ? S_SETTLE : run_st;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         lfsr_q         <= SEED_EFF;
         mem_q          <= '0;
         op7_q          <= '0;
         count_q        <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         hold_q         <= '0;
         issue_q        <= '0;
         mode_q         <= '0;
         settle_armed_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         mem_q          <= mem_d;
         op7_q          <= op7_d;
         count_q        <= count_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         hold_q         <= hold_d;
         issue_q        <= issue_d;
         mode_q         <= mode_d;
         settle_armed_q <= settle_armed_d;
      end
   end

   assign ifu_rd_req     = 1'b0;
   assign ifu_rd_addr    = '0;
   assign base_addr      = START_ADDR;
   assign pdp_mem_opcode = mem_q;
   assign pdp_op7_opcode = op7_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign instr_count    = count_q;

endmodule

// File: tb/tb_pdp8_stim_sequencer.sv
// Randomized bench for pdp8_stim_sequencer: two configurations checked cycle by cycle
// against a reference model built from the sequencing and LFSR rules.
module tb_pdp8_stim_sequencer;

   localparam int unsigned AW      = 12;
   localparam logic [21:0] OP7_CLA = 22'h000800;
   localparam logic [21:0] OP7_NOP = 22'h000001;

   logic          clk, reset_n, start_a, start_b, stall;
   logic [1:0]    mode;
   logic [AW-1:0] pc_value;

   logic          ifu_rd_req_a, ifu_rd_req_b, busy_a, busy_b, done_a, done_b;
   logic [AW-1:0] ifu_rd_addr_a, ifu_rd_addr_b, base_addr_a, base_addr_b;
   logic [17:0]   mem_a, mem_b;
   logic [21:0]   op7_a, op7_b;
   logic [31:0]   count_a, count_b;

   pdp8_stim_sequencer #(
      .ADDR_WIDTH(AW), .START_ADDR(12'o200), .SEED(18'h2A5F3), .NUM_MEM(40), .NUM_OP7(12),
      .HOLD_CYC(4), .PREAMBLE_EN(1'b1), .ONEHOT_EN(1'b0)
   ) u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode), .stall(stall),
      .PC_value(pc_value), .ifu_rd_req(ifu_rd_req_a), .ifu_rd_addr(ifu_rd_addr_a),
      .base_addr(base_addr_a), .pdp_mem_opcode(mem_a), .pdp_op7_opcode(op7_a),
      .busy(busy_a), .done(done_a), .instr_count(count_a)
   );

   pdp8_stim_sequencer #(
      .ADDR_WIDTH(AW), .START_ADDR(12'o200), .SEED(18'h00000), .NUM_MEM(600), .NUM_OP7(400),
      .HOLD_CYC(1), .PREAMBLE_EN(1'b0), .ONEHOT_EN(1'b1)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode), .stall(stall),
      .PC_value(pc_value), .ifu_rd_req(ifu_rd_req_b), .ifu_rd_addr(ifu_rd_addr_b),
      .base_addr(base_addr_b), .pdp_mem_opcode(mem_b), .pdp_op7_opcode(op7_b),
      .busy(busy_b), .done(done_b), .instr_count(count_b)
   );

   bit          sel;
   logic [17:0] obs_mem;
   logic [21:0] obs_op7;
   logic [31:0] obs_count;
   logic        obs_busy, obs_done;

   assign obs_mem   = sel ? mem_b   : mem_a;
   assign obs_op7   = sel ? op7_b   : op7_a;
   assign obs_count = sel ? count_b : count_a;
   assign obs_busy  = sel ? busy_b  : busy_a;
   assign obs_done  = sel ? done_b  : done_a;

   int          p_mem[2]  = '{40, 600};
   int          p_op7[2]  = '{12, 400};
   int          p_hold[2] = '{4, 1};
   bit          p_pre[2]  = '{1'b1, 1'b0};
   bit          p_oh[2]   = '{1'b0, 1'b1};
   logic [17:0] p_seed[2] = '{18'h2A5F3, 18'h00001};

   logic [17:0] m_lfsr[2];
   logic [17:0] exp_mem;
   logic [21:0] exp_op7;
   logic [31:0] exp_count;
   logic        exp_busy, exp_done;

   int n_checks = 0;
   int n_errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s dut=%h model=%h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   task automatic cycle_check();
      check("mem_opcode", 32'(obs_mem), 32'(exp_mem));
      check("op7_opcode", 32'(obs_op7), 32'(exp_op7));
      check("instr_count", obs_count, exp_count);
      check("busy", 32'(obs_busy), 32'(exp_busy));
      check("done", 32'(obs_done), 32'(exp_done));
   endtask

   // x^18 + x^11 + 1, shifted left with the feedback entering bit 0
   function automatic logic [17:0] lfsr_step(input logic [17:0] x);
      int v = int'(x);
      return 18'(((v * 2) & 'h3FFFF) | (((v >> 17) ^ (v >> 10)) & 1));
   endfunction

   function automatic logic [17:0] mem_of(input logic [17:0] l, input bit oh);
      int v = int'(l);
      if (!oh) return l;
      return 18'((1 << (12 + ((v >> 15) % 6))) | (v & 'hFFF));
   endfunction

   function automatic logic [21:0] op7_of(input logic [17:0] l);
      int v = int'(l);
      return 22'(((v & 'hF) << 18) | v);
   endfunction

   task automatic run_seq(input bit s, input logic [1:0] md, input int pct, input bit burst,
                          input int rst_at);
      int total, issued, pre_len, h, guard, burst_left, mem_obs, op7_obs, n_mem, n_op7;
      bit fin, burst_done, is_mem;
      logic [17:0] l;

      sel   = s;
      mode  = md;
      stall = 1'b0;
      if (s) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      mode = 2'($urandom);
      exp_busy = 1'b1; exp_done = 1'b0; exp_count = '0; exp_mem = '0; exp_op7 = '0;
      cycle_check();

      h       = p_hold[s];
      pre_len = p_pre[s] ? 3 * h : h;
      for (int i = 1; i <= pre_len; i++) begin
         @(negedge clk);
         if (p_pre[s] && i <= h)          exp_op7 = OP7_CLA;
         else if (p_pre[s] && i <= 2 * h) exp_op7 = OP7_NOP;
         else                             exp_op7 = '0;
         cycle_check();
      end

      case (md)
         2'b01:   total = p_mem[s];
         2'b10:   total = p_op7[s];
         default: total = p_mem[s] + p_op7[s];
      endcase
      issued = 0; guard = 0; burst_left = 0; burst_done = 1'b0; fin = 1'b0;
      mem_obs = 0; op7_obs = 0; n_mem = 0; n_op7 = 0;

      while (!fin && guard < 20000) begin
         guard++;
         if (rst_at >= 0 && exp_count == 32'(rst_at)) begin
            reset_n = 1'b0;
            stall   = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            m_lfsr[0] = p_seed[0];
            m_lfsr[1] = p_seed[1];
            exp_mem = '0; exp_op7 = '0; exp_count = '0; exp_busy = 1'b0; exp_done = 1'b0;
            cycle_check();
            repeat (3) begin
               @(negedge clk);
               cycle_check();
            end
            return;
         end
         if (burst && issued == 2 && !burst_done) begin
            burst_left = 10;
            burst_done = 1'b1;
         end
         if (burst_left > 0) begin
            stall = 1'b1;
            burst_left--;
         end else begin
            stall = (int'($urandom_range(99)) < pct);
         end
         if ($urandom_range(15) == 0) begin
            if (s) start_b = 1'b1; else start_a = 1'b1;
            mode = 2'($urandom);
         end
         @(negedge clk);
         start_a = 1'b0; start_b = 1'b0;
         if (!stall) begin
            l = lfsr_step(m_lfsr[s]);
            m_lfsr[s] = l;
            is_mem = (md == 2'b01) || (md == 2'b00 && issued < p_mem[s]) ||
                     (md == 2'b11 && l[0] == 1'b0);
            exp_mem = is_mem ? mem_of(l, p_oh[s]) : '0;
            exp_op7 = is_mem ? '0 : op7_of(l);
            exp_count++;
            issued++;
            if (is_mem) n_mem++; else n_op7++;
            if (obs_mem != '0) mem_obs++;
            else if (obs_op7 != '0) op7_obs++;
            if (is_mem && p_oh[s]) check("onehot_flags", 32'($countones(obs_mem[17:12])), 32'd1);
            fin = (issued == total);
         end
         cycle_check();
      end
      if (!fin) check("run_timeout_issues", 32'(issued), 32'(total));

      stall = 1'($urandom);
      @(negedge clk);
      exp_mem = '0; exp_op7 = '0; exp_busy = 1'b0; exp_done = 1'b1;
      cycle_check();
      check("mem_issues", 32'(mem_obs), 32'(n_mem));
      check("op7_issues", 32'(op7_obs), 32'(n_op7));
      check("total_issues", 32'(mem_obs + op7_obs), 32'(total));
      @(negedge clk);
      cycle_check();
   endtask

   initial begin
      reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stall = 1'b0; mode = 2'b00;
      pc_value = 12'($urandom);
      sel = 1'b0;
      m_lfsr[0] = p_seed[0];
      m_lfsr[1] = p_seed[1];
      exp_mem = '0; exp_op7 = '0; exp_count = '0; exp_busy = 1'b0; exp_done = 1'b0;
      repeat (2) @(negedge clk);
      cycle_check();
      check("base_addr", 32'(base_addr_a), 32'(12'o200));
      check("ifu_rd_req", 32'(ifu_rd_req_a), 32'd0);
      check("ifu_rd_addr", 32'(ifu_rd_addr_a), 32'd0);
      sel = 1'b1;
      cycle_check();
      reset_n = 1'b1;
      sel = 1'b0;
      repeat (2) begin
         @(negedge clk);
         cycle_check();
      end

      run_seq(1'b0, 2'b01, 0, 1'b1, -1);
      run_seq(1'b0, 2'b00, 30, 1'b0, -1);
      run_seq(1'b0, 2'b10, 50, 1'b0, -1);
      run_seq(1'b0, 2'b11, 20, 1'b0, -1);
      run_seq(1'b0, 2'b01, 25, 1'b0, 37);
      run_seq(1'b0, 2'b01, 0, 1'b0, -1);
      run_seq(1'b1, 2'b11, 30, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
